wb_flash_arbiter: RTL and testbench

Two-master Wishbone arbiter that shares the single QSPI flash read controller between the CPU instruction bus (master 0) and data bus (master 1). It grants the slave to one master at a time, round-robin on contention, and holds the grant for the whole Wishbone cycle, so sequential instruction fetches keep the flash in continuous-read mode. It sits between the CPU bus interfaces and the flash controller, with an optional watchdog that terminates hung transfers with an error.

---
 rtl/wb_flash_arbiter_if.sv | 40 ++++
 rtl/wb_flash_arbiter.sv | 139 +++++++++++++
 tb/tb_wb_flash_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_flash_arbiter_if.sv
// Wishbone bundle between the two CPU masters, the arbiter and the flash read controller.
// Modport slave is the arbiter's view; modport master is the surrounding CPU/flash side.
interface wb_flash_arbiter_if #(
  parameter int unsigned AW = 24,
  parameter int unsigned DW = 32
);
  logic [AW-1:0]   m0_adr_i, m1_adr_i;
  logic [DW-1:0]   m0_dat_i, m1_dat_i;
  logic [DW-1:0]   m0_dat_o, m1_dat_o;
  logic            m0_we_i,  m1_we_i;
  logic [DW/8-1:0] m0_sel_i, m1_sel_i;
  logic            m0_stb_i, m1_stb_i;
  logic            m0_cyc_i, m1_cyc_i;
  logic            m0_ack_o, m1_ack_o;
  logic            m0_err_o, m1_err_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic            s_we_o;
  logic [DW/8-1:0] s_sel_o;
  logic            s_stb_o;
  logic            s_cyc_o;
  logic [DW-1:0]   s_dat_i;
  logic            s_ack_i;

  modport slave (
    input  m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i, m0_we_i, m1_we_i,
    input  m0_sel_i, m1_sel_i, m0_stb_i, m1_stb_i, m0_cyc_i, m1_cyc_i,
    output m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
    output s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o,
    input  s_dat_i, s_ack_i
  );

  modport master (
    output m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i, m0_we_i, m1_we_i,
    output m0_sel_i, m1_sel_i, m0_stb_i, m1_stb_i, m0_cyc_i, m1_cyc_i,
    input  m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
    input  s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o,
    output s_dat_i, s_ack_i
  );
endinterface

// File: rtl/wb_flash_arbiter.sv
// Round-robin two-master Wishbone arbiter in front of the QSPI flash read controller.
// Define WB_ARB_TIMEOUT_EN to add the watchdog that errors out hung transfers and flushes.
module wb_flash_arbiter #(
  parameter int unsigned AW      = 24,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input logic               wb_clk_i,
  input logic               wb_reset_n_i,
  wb_flash_arbiter_if.slave bus
);

  if ((TIMEOUT == 0) || (TIMEOUT > 32'd65535)) begin : gen_bad_timeout
    $error("TIMEOUT must be in 1..65535");
  end

`ifdef WB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1, StFlush} state_e;
`else
  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;
`endif

  state_e r_state;
  logic   r_last_gnt;

  logic            w_req0, w_req1;
  logic            w_gnt0, w_gnt1;
  logic            w_gnt_cyc, w_gnt_stb;
  logic [AW-1:0]   w_adr;
  logic [DW-1:0]   w_dat;
  logic [DW/8-1:0] w_sel;
  logic            w_we;

  assign w_req0    = bus.m0_cyc_i & bus.m0_stb_i;
  assign w_req1    = bus.m1_cyc_i & bus.m1_stb_i;
  assign w_gnt0    = (r_state == StGnt0);
  assign w_gnt1    = (r_state == StGnt1);
  assign w_gnt_cyc = (w_gnt0 & bus.m0_cyc_i) | (w_gnt1 & bus.m1_cyc_i);
  assign w_gnt_stb = (w_gnt0 & bus.m0_stb_i) | (w_gnt1 & bus.m1_stb_i);

  // Mux select comes only from the registered state, never from a request line.
  always_comb begin
    w_adr = '0;
    w_dat = '0;
    w_sel = '0;
    w_we  = 1'b0;
    if (w_gnt0) begin
      w_adr = bus.m0_adr_i;
      w_dat = bus.m0_dat_i;
      w_sel = bus.m0_sel_i;
      w_we  = bus.m0_we_i;
    end else if (w_gnt1) begin
      w_adr = bus.m1_adr_i;
      w_dat = bus.m1_dat_i;
      w_sel = bus.m1_sel_i;
      w_we  = bus.m1_we_i;
    end
  end

  assign bus.s_adr_o  = w_adr;
  assign bus.s_dat_o  = w_dat;
  assign bus.s_sel_o  = w_sel;
  assign bus.s_we_o   = w_we;
  assign bus.s_cyc_o  = w_gnt_cyc;
  assign bus.s_stb_o  = w_gnt_stb;
  assign bus.m0_dat_o = bus.s_dat_i;
  assign bus.m1_dat_o = bus.s_dat_i;
  assign bus.m0_ack_o = w_gnt0 & bus.s_ack_i;
  assign bus.m1_ack_o = w_gnt1 & bus.s_ack_i;

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] TimeoutCnt  = 16'(TIMEOUT);
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  logic [15:0] r_wdog_cnt;
  logic        w_timeout;

  // A same-cycle ack beats the watchdog.
  assign w_timeout    = w_gnt_stb & ~bus.s_ack_i & (r_wdog_cnt == TimeoutCnt);
  assign bus.m0_err_o = w_gnt0 & w_timeout;
  assign bus.m1_err_o = w_gnt1 & w_timeout;
`else
  assign bus.m0_err_o = 1'b0;
  assign bus.m1_err_o = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (!wb_reset_n_i) begin
      r_state    <= StIdle;
      r_last_gnt <= 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
      r_wdog_cnt <= '0;
`endif
    end else begin
      case (r_state)
        StIdle: begin
          if (w_req0 && (!w_req1 || r_last_gnt)) begin
            r_state    <= StGnt0;
            r_last_gnt <= 1'b0;
          end else if (w_req1) begin
            r_state    <= StGnt1;
            r_last_gnt <= 1'b1;
          end
        end
        StGnt0, StGnt1: begin
`ifdef WB_ARB_TIMEOUT_EN
          if (w_timeout) begin
            r_state    <= StFlush;
            r_wdog_cnt <= '0;
          end else if (!w_gnt_cyc) begin
            r_state    <= StIdle;
            r_wdog_cnt <= '0;
          end else if (bus.s_ack_i) begin
            r_wdog_cnt <= '0;
          end else if (w_gnt_stb) begin
            r_wdog_cnt <= r_wdog_cnt + 16'd1;
          end
`else
          if (!w_gnt_cyc) begin
            r_state <= StIdle;
          end
`endif
        end
`ifdef WB_ARB_TIMEOUT_EN
        StFlush: begin
          if (r_wdog_cnt == TimeoutLast) begin
            r_state    <= StIdle;
            r_wdog_cnt <= '0;
          end else begin
            r_wdog_cnt <= r_wdog_cnt + 16'd1;
          end
        end
`endif
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_flash_arbiter.sv
// Directed self-checking bench for wb_flash_arbiter; covers the default and the
// WB_ARB_TIMEOUT_EN build (watchdog limit 8).
module tb_wb_flash_arbiter;

  localparam int unsigned Tmo = 8;
`ifdef WB_ARB_TIMEOUT_EN
  localparam int AckDly = 6;
`else
  localparam int AckDly = 10;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   bad;

  wb_flash_arbiter_if #(.AW(24), .DW(32)) bus ();

  wb_flash_arbiter #(
    .AW     (24),
    .DW     (32),
    .TIMEOUT(Tmo)
  ) dut (
    .wb_clk_i    (clk),
    .wb_reset_n_i(rst_n),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req0(input logic on, input logic [23:0] adr);
    bus.m0_cyc_i = on;
    bus.m0_stb_i = on;
    bus.m0_adr_i = adr;
  endtask

  task automatic req1(input logic on, input logic [23:0] adr);
    bus.m1_cyc_i = on;
    bus.m1_stb_i = on;
    bus.m1_adr_i = adr;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    req0(1'b0, 24'h0);
    req1(1'b0, 24'h0);
    bus.m0_dat_i = 32'h0; bus.m1_dat_i = 32'h0;
    bus.m0_we_i = 1'b0;   bus.m1_we_i = 1'b0;
    bus.m0_sel_i = 4'hf;  bus.m1_sel_i = 4'hf;
    bus.s_dat_i = 32'h0;
    bus.s_ack_i = 1'b1;  // stray ack during reset must be dropped
    repeat (2) step();
    #1;
    check("rst_cyc", bus.s_cyc_o, 0);
    check("rst_stb", bus.s_stb_o, 0);
    check("rst_ack0", bus.m0_ack_o, 0);
    check("rst_ack1", bus.m1_ack_o, 0);
    check("rst_err", {bus.m0_err_o, bus.m1_err_o}, 0);
    rst_n = 1'b1;
    bus.s_ack_i = 1'b0;
    step();

    // Single read by m0
    req0(1'b1, 24'h000010);
    #1;
    check("t1_stb_pre", bus.s_stb_o, 0);
    step();
    #1;
    check("t1_stb", bus.s_stb_o, 1);
    check("t1_adr", bus.s_adr_o, 32'h10);
    repeat (AckDly - 1) step();
    step();
    bus.s_ack_i = 1'b1;
    bus.s_dat_i = 32'hDEADBEEF;
    #1;
    check("t1_ack0", bus.m0_ack_o, 1);
    check("t1_dat0", bus.m0_dat_o, 32'hDEADBEEF);
    check("t1_ack1", bus.m1_ack_o, 0);
    step();
    bus.s_ack_i = 1'b0;
    req0(1'b0, 24'h0);
    #1;
    check("t1_drop", bus.s_cyc_o, 0);
    step();

    // Tie after reset, then round robin
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req0(1'b1, 24'h000100);
    req1(1'b1, 24'h000200);
    step();
    #1;
    check("t2_tie_m0", bus.s_adr_o, 32'h100);
    bus.s_ack_i = 1'b1;
    #1;
    check("t2_ack0", bus.m0_ack_o, 1);
    check("t2_noack1", bus.m1_ack_o, 0);
    step();
    bus.s_ack_i = 1'b0;
    req0(1'b0, 24'h0);
    #1;
    check("t2_drop_cyc", bus.s_cyc_o, 0);
    step();
    #1;
    check("t2_idle_gap", bus.s_stb_o, 0);
    step();
    #1;
    check("t2_m1_adr", bus.s_adr_o, 32'h200);
    check("t2_m1_stb", bus.s_stb_o, 1);
    bus.s_ack_i = 1'b1;
    #1;
    check("t2_ack1", bus.m1_ack_o, 1);
    check("t2_noack0", bus.m0_ack_o, 0);
    step();
    bus.s_ack_i = 1'b0;
    req1(1'b0, 24'h0);
    step();
    req0(1'b1, 24'h000100);
    req1(1'b1, 24'h000200);
    step();
    #1;
    check("t2_tie2_m0", bus.s_adr_o, 32'h100);
    bus.s_ack_i = 1'b1;
    step();
    bus.s_ack_i = 1'b0;
    req0(1'b0, 24'h0);
    req1(1'b0, 24'h0);
    step();
    req0(1'b1, 24'h000100);
    req1(1'b1, 24'h000200);
    step();
    #1;
    check("t2_tie3_m1", bus.s_adr_o, 32'h200);
    bus.s_ack_i = 1'b1;
    step();
    bus.s_ack_i = 1'b0;
    req0(1'b0, 24'h0);
    req1(1'b0, 24'h0);
    step();

    // Four-beat m0 burst with m1 waiting
    req0(1'b1, 24'h000010);
    req1(1'b1, 24'h000300);
    step();
    for (int i = 0; i < 4; i++) begin
      bus.m0_adr_i = 24'h000010 + 24'(i);
      bus.s_ack_i = 1'b1;
      #1;
      check("t3_ack0", bus.m0_ack_o, 1);
      check("t3_cyc", bus.s_cyc_o, 1);
      check("t3_adr", bus.s_adr_o, 32'h10 + 32'(i));
      check("t3_noack1", bus.m1_ack_o, 0);
      step();
    end
    bus.s_ack_i = 1'b0;
    req0(1'b0, 24'h0);
    #1;
    check("t3_drop", bus.s_cyc_o, 0);
    step();
    #1;
    check("t3_idle", bus.s_cyc_o, 0);
    step();
    #1;
    check("t3_m1_adr", bus.s_adr_o, 32'h300);
    bus.s_ack_i = 1'b1;
    #1;
    check("t3_ack1", bus.m1_ack_o, 1);
    step();
    bus.s_ack_i = 1'b0;
    #1;
    check("t3_m1_hold", bus.s_stb_o, 1);

    // Reset while GNT1 awaits ack
    rst_n = 1'b0;
    req1(1'b0, 24'h0);
    step();
    #1;
    check("t4_rst_cyc", bus.s_cyc_o, 0);
    rst_n = 1'b1;
    step();
    step();
    bus.s_ack_i = 1'b1;
    #1;
    check("t4_ack1", bus.m1_ack_o, 0);
    check("t4_ack0", bus.m0_ack_o, 0);
    check("t4_stb", bus.s_stb_o, 0);
    step();
    bus.s_ack_i = 1'b0;

    // Slave never acks m1; m0 pending
    req1(1'b1, 24'h000400);
    step();
    #1;
    check("t5_stb", bus.s_stb_o, 1);
    check("t5_adr", bus.s_adr_o, 32'h400);
    req0(1'b1, 24'h000500);
`ifdef WB_ARB_TIMEOUT_EN
    bad = 0;
    for (int k = 1; k < int'(Tmo); k++) begin
      step();
      #1;
      if (bus.m1_err_o !== 1'b0) bad++;
    end
    check("t5_early_err", bad, 0);
    step();
    #1;
    check("t5_err1", bus.m1_err_o, 1);
    check("t5_err0", bus.m0_err_o, 0);
    check("t5_err_stb", bus.s_stb_o, 1);
    step();
    req1(1'b0, 24'h0);
    bus.s_ack_i = 1'b1;
    #1;
    check("t5_flush_cyc", bus.s_cyc_o, 0);
    check("t5_flush_err", bus.m1_err_o, 0);
    bad = 0;
    for (int k = 1; k < int'(Tmo); k++) begin
      step();
      #1;
      if (bus.s_cyc_o | bus.s_stb_o | bus.m0_ack_o | bus.m1_ack_o) bad++;
    end
    check("t5_flush_len", bad, 0);
    step();
    bus.s_ack_i = 1'b0;
    #1;
    check("t5_idle", bus.s_cyc_o, 0);
    step();
    #1;
    check("t5_m0_adr", bus.s_adr_o, 32'h500);
    check("t5_m0_stb", bus.s_stb_o, 1);
`else
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      #1;
      if (bus.m1_err_o !== 1'b0 || bus.s_stb_o !== 1'b1 || bus.s_adr_o !== 24'h000400) bad++;
    end
    check("t5_hold", bad, 0);
    req1(1'b0, 24'h0);
    step();
    #1;
    check("t5_idle", bus.s_cyc_o, 0);
    step();
    #1;
    check("t5_m0_adr", bus.s_adr_o, 32'h500);
    check("t5_m0_stb", bus.s_stb_o, 1);
`endif
    req0(1'b0, 24'h0);
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
